// File: rtl/psum_ctrl_pkg.sv
// psum_ctrl_pkg: shared widths, FSM state encoding and PSUM SRAM control polarities
package psum_ctrl_pkg;
    localparam int default_addr_bw = 11;
    localparam int default_cnt_bw  = 11;
    localparam int default_psum_bw = 16;
    localparam logic [2:0] st_idle = 3'd0;
    localparam logic [2:0] st_wait = 3'd1;
    localparam logic [2:0] st_rd   = 3'd2;
    localparam logic [2:0] st_wr   = 3'd3;
    localparam logic [2:0] st_fin  = 3'd4;
    localparam logic cen_on  = 1'b0;
    localparam logic cen_off = 1'b1;
    localparam logic wen_on  = 1'b0;
    localparam logic wen_off = 1'b1;
    localparam logic ren_on  = 1'b1;
    localparam logic ren_off = 1'b0;
endpackage

// File: rtl/psum_accum_ctrl.sv
// psum_accum_ctrl: per-tile read-modify-write sequencer draining the OFIFO into the PSUM SRAM via the SFP
//   clk, reset (async, active-low)     : clock and reset
//   start, cfg_base, cfg_len, cfg_first: tile launch and configuration
//   ofifo_valid / ofifo_rd             : OFIFO handshake (one vector per pop)
//   CEN_pmem, WEN_pmem, REN_pmem, A_pmem: PSUM SRAM control
//   acc, passthrough                   : SFP mode selects, asserted only in the write cycle
//   busy, done                         : tile status; done pulses once per tile
//   stall_cnt                          : present only with PSUM_CTRL_STALL_CNT_EN defined
module psum_accum_ctrl
    import psum_ctrl_pkg::*;
#(
    parameter int addr_bw = default_addr_bw,
    parameter int cnt_bw  = default_cnt_bw
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] cfg_base,
    input  logic [cnt_bw-1:0]  cfg_len,
    input  logic               cfg_first,
    input  logic               ofifo_valid,
    output logic               ofifo_rd,
    output logic               CEN_pmem,
    output logic               WEN_pmem,
    output logic               REN_pmem,
    output logic [addr_bw-1:0] A_pmem,
    output logic               acc,
    output logic               passthrough,
    output logic               busy,
`ifdef PSUM_CTRL_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               done
);
    logic [2:0]         state, state_nxt;
    logic [addr_bw-1:0] addr, addr_nxt;
    logic [cnt_bw-1:0]  remaining, rem_nxt;
    logic               mode, mode_nxt;
    logic               rd_nxt, wr_nxt;

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr;
        rem_nxt   = remaining;
        mode_nxt  = mode;
        case (state)
            st_idle: if (start) begin
                addr_nxt  = cfg_base;
                rem_nxt   = cfg_len;
                mode_nxt  = cfg_first;
                state_nxt = (cfg_len == '0) ? st_fin : st_wait;
            end
            st_wait: state_nxt = ofifo_valid ? st_rd : st_wait;
            st_rd:   state_nxt = st_wr;
            st_wr: begin
                addr_nxt  = addr + addr_bw'(1);
                rem_nxt   = remaining - cnt_bw'(1);
                state_nxt = (remaining == cnt_bw'(1)) ? st_fin : (ofifo_valid ? st_rd : st_wait);
            end
            st_fin:  state_nxt = st_idle;
            default: state_nxt = st_idle;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe
    assign rd_nxt = state_nxt == st_rd;
    assign wr_nxt = state_nxt == st_wr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= st_idle;
            addr        <= '0;
            remaining   <= '0;
            mode        <= 1'b0;
            ofifo_rd    <= 1'b0;
            CEN_pmem    <= cen_off;
            WEN_pmem    <= wen_off;
            REN_pmem    <= ren_off;
            A_pmem      <= '0;
            acc         <= 1'b0;
            passthrough <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= rem_nxt;
            mode        <= mode_nxt;
            ofifo_rd    <= rd_nxt;
            // First-pass tiles skip the SRAM read: the SFP passes OFIFO data straight through
            CEN_pmem    <= (wr_nxt || (rd_nxt && !mode_nxt)) ? cen_on : cen_off;
            WEN_pmem    <= wr_nxt ? wen_on : wen_off;
            REN_pmem    <= (rd_nxt && !mode_nxt) ? ren_on : ren_off;
            if (rd_nxt || wr_nxt)
                A_pmem  <= addr_nxt;
            acc         <= wr_nxt && !mode_nxt;
            passthrough <= wr_nxt && mode_nxt;
            busy        <= state_nxt inside {st_wait, st_rd, st_wr};
            done        <= state_nxt == st_fin;
        end
    end

`ifdef PSUM_CTRL_STALL_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt <= '0;
        else if (state == st_idle && start)
            stall_cnt <= '0;
        else if (state == st_wait && !ofifo_valid && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_psum_accum_ctrl.sv
// tb_psum_accum_ctrl: directed bench for psum_accum_ctrl with an SRAM/OFIFO/SFP model
module tb_psum_accum_ctrl;
    logic        clk, reset, start, cfg_first, ofifo_valid;
    logic [10:0] cfg_base, cfg_len;
    logic        ofifo_rd, CEN_pmem, WEN_pmem, REN_pmem, acc, passthrough, busy, done;
    logic [10:0] A_pmem;
`ifdef PSUM_CTRL_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    psum_accum_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .cfg_first(cfg_first), .ofifo_valid(ofifo_valid), .ofifo_rd(ofifo_rd),
        .CEN_pmem(CEN_pmem), .WEN_pmem(WEN_pmem), .REN_pmem(REN_pmem), .A_pmem(A_pmem),
        .acc(acc), .passthrough(passthrough), .busy(busy),
`ifdef PSUM_CTRL_STALL_CNT_EN
        .stall_cnt(stall_cnt),
`endif
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ofifo_rd, CEN, WEN, REN, acc, passthrough, busy, done}
    wire  [7:0] ctl = {ofifo_rd, CEN_pmem, WEN_pmem, REN_pmem, acc, passthrough, busy, done};
    localparam logic [7:0] c_idle = 8'b0110_0000;
    localparam logic [7:0] c_wait = 8'b0110_0010;
    localparam logic [7:0] c_rda  = 8'b1011_0010;
    localparam logic [7:0] c_rdf  = 8'b1110_0010;
    localparam logic [7:0] c_wra  = 8'b0000_1010;
    localparam logic [7:0] c_wrf  = 8'b0000_0110;
    localparam logic [7:0] c_fin  = 8'b0110_0001;

    // SRAM (1-cycle read latency), OFIFO and SFP model
    logic [15:0] mem [0:2047];
    logic [15:0] q, fifo_out;
    logic [15:0] fifo_tbl [0:16];
    int          rd_idx = 0;
    logic        pl_en = 1'b0;
    logic [10:0] pl_a;
    logic [15:0] pl_d;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        if (!CEN_pmem && REN_pmem) q <= mem[A_pmem];
        if (!CEN_pmem && !WEN_pmem) mem[A_pmem] <= passthrough ? fifo_out : (acc ? q + fifo_out : q);
        if (ofifo_rd) begin
            fifo_out <= fifo_tbl[rd_idx];
            rd_idx   <= rd_idx + 1;
        end
    end

    always @(negedge clk) if (reset) begin
        checks++;
        assert (!(REN_pmem && !WEN_pmem) && !(ofifo_rd && !ofifo_valid)) else begin
            errors++;
            $error("FAIL protocol: ren=%b wen=%b rd=%b valid=%b", REN_pmem, WEN_pmem, ofifo_rd, ofifo_valid);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [7:0] e, input int a);
        step();
        chk(tag, {24'd0, ctl}, {24'd0, e});
        if (a >= 0) chk({tag, " addr"}, {21'd0, A_pmem}, a);
    endtask

    task automatic go(input int base, input int len, input logic first);
        start = 1'b1;
        cfg_base = 11'(base);
        cfg_len = 11'(len);
        cfg_first = first;
        step();
        start = 1'b0;
    endtask

    task automatic preload(input int a, input logic [15:0] d);
        pl_en = 1'b1;
        pl_a = 11'(a);
        pl_d = d;
        step();
        pl_en = 1'b0;
    endtask

    initial begin
        fifo_tbl = '{16'd1, 16'd2, 16'd3, 16'd7, 16'd9, 16'd5, 16'd6, 16'd11, 16'd12,
                     16'd13, 16'd41, 16'd42, 16'd21, 16'd22, 16'd31, 16'd32, 16'd33};
        reset = 1'b0; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_first = 1'b0; ofifo_valid = 1'b0;
        #1;
        preload(5, 16'd100);
        preload(6, 16'd200);
        preload(7, 16'd300);
        preload(10, 16'd1000);
        preload(11, 16'd2000);
        preload(500, 16'h1234);
        chk("reset ctl", {24'd0, ctl}, {24'd0, c_idle});
        chk("reset addr", {21'd0, A_pmem}, 0);
`ifdef PSUM_CTRL_STALL_CNT_EN
        chk("reset stall_cnt", {16'd0, stall_cnt}, 0);
`endif
        reset = 1'b1;
        cyc("idle after release", c_idle, 0);

        // accumulate tile: 5..7, FIFO always valid
        ofifo_valid = 1'b1;
        go(5, 3, 1'b0);
        chk("t1 wait", {24'd0, ctl}, {24'd0, c_wait});
        for (int i = 0; i < 3; i++) begin
            cyc("t1 rd", c_rda, 5 + i);
            cyc("t1 wr", c_wra, 5 + i);
        end
        cyc("t1 fin", c_fin, -1);
        cyc("t1 idle", c_idle, -1);
        chk("t1 mem5", {16'd0, mem[5]}, 101);
        chk("t1 mem6", {16'd0, mem[6]}, 202);
        chk("t1 mem7", {16'd0, mem[7]}, 303);
`ifdef PSUM_CTRL_STALL_CNT_EN
        chk("t1 stall_cnt", {16'd0, stall_cnt}, 0);
`endif

        // first-pass tile: passthrough, no reads
        go(0, 2, 1'b1);
        chk("t2 wait", {24'd0, ctl}, {24'd0, c_wait});
        for (int i = 0; i < 2; i++) begin
            cyc("t2 rd", c_rdf, i);
            cyc("t2 wr", c_wrf, i);
        end
        cyc("t2 fin", c_fin, -1);
        chk("t2 mem0", {16'd0, mem[0]}, 7);
        chk("t2 mem1", {16'd0, mem[1]}, 9);
        step();

        // FIFO stall for 4 cycles after the first vector
        go(10, 2, 1'b0);
        chk("t3 wait", {24'd0, ctl}, {24'd0, c_wait});
        cyc("t3 rd0", c_rda, 10);
        cyc("t3 wr0", c_wra, 10);
        ofifo_valid = 1'b0;
        repeat (4) cyc("t3 stall", c_wait, -1);
        cyc("t3 wait valid", c_wait, -1);
        ofifo_valid = 1'b1;
        cyc("t3 rd1", c_rda, 11);
        cyc("t3 wr1", c_wra, 11);
        cyc("t3 fin", c_fin, -1);
        cyc("t3 idle", c_idle, -1);
        chk("t3 mem10", {16'd0, mem[10]}, 1005);
        chk("t3 mem11", {16'd0, mem[11]}, 2006);
`ifdef PSUM_CTRL_STALL_CNT_EN
        chk("t3 stall_cnt", {16'd0, stall_cnt}, 4);
`endif

        // address wrap
        go(2046, 3, 1'b1);
        chk("t4 wait", {24'd0, ctl}, {24'd0, c_wait});
        cyc("t4 rd0", c_rdf, 2046);
        cyc("t4 wr0", c_wrf, 2046);
        cyc("t4 rd1", c_rdf, 2047);
        cyc("t4 wr1", c_wrf, 2047);
        cyc("t4 rd2", c_rdf, 0);
        cyc("t4 wr2", c_wrf, 0);
        cyc("t4 fin", c_fin, -1);
        cyc("t4 idle", c_idle, -1);
        chk("t4 mem2046", {16'd0, mem[2046]}, 11);
        chk("t4 mem2047", {16'd0, mem[2047]}, 12);
        chk("t4 mem0", {16'd0, mem[0]}, 13);

        // zero length
        go(33, 0, 1'b0);
        chk("t5 fin", {24'd0, ctl}, {24'd0, c_fin});
        cyc("t5 idle", c_idle, -1);

        // reset during WR of vector 2 of 4
        go(100, 4, 1'b0);
        chk("t6 wait", {24'd0, ctl}, {24'd0, c_wait});
        cyc("t6 rd0", c_rda, 100);
        cyc("t6 wr0", c_wra, 100);
        cyc("t6 rd1", c_rda, 101);
        cyc("t6 wr1", c_wra, 101);
        reset = 1'b0;
        #1;
        chk("t6 async ctl", {24'd0, ctl}, {24'd0, c_idle});
        chk("t6 async addr", {21'd0, A_pmem}, 0);
`ifdef PSUM_CTRL_STALL_CNT_EN
        chk("t6 stall_cnt", {16'd0, stall_cnt}, 0);
`endif
        repeat (3) cyc("t6 held", c_idle, 0);
        reset = 1'b1;
        go(200, 2, 1'b1);
        chk("t6 wait", {24'd0, ctl}, {24'd0, c_wait});
        for (int i = 0; i < 2; i++) begin
            cyc("t6 rd", c_rdf, 200 + i);
            cyc("t6 wr", c_wrf, 200 + i);
        end
        cyc("t6 fin", c_fin, -1);
        cyc("t6 idle", c_idle, -1);
        chk("t6 mem200", {16'd0, mem[200]}, 21);
        chk("t6 mem201", {16'd0, mem[201]}, 22);

        // start while busy is ignored
        go(300, 3, 1'b1);
        chk("t7 wait", {24'd0, ctl}, {24'd0, c_wait});
        cyc("t7 rd0", c_rdf, 300);
        start = 1'b1;
        cfg_base = 11'd500;
        cfg_len = 11'd1;
        cyc("t7 wr0", c_wrf, 300);
        start = 1'b0;
        cyc("t7 rd1", c_rdf, 301);
        cyc("t7 wr1", c_wrf, 301);
        cyc("t7 rd2", c_rdf, 302);
        cyc("t7 wr2", c_wrf, 302);
        cyc("t7 fin", c_fin, -1);
        cyc("t7 idle", c_idle, -1);
        chk("t7 mem300", {16'd0, mem[300]}, 31);
        chk("t7 mem302", {16'd0, mem[302]}, 33);
        chk("t7 mem500", {16'd0, mem[500]}, 32'h1234);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
